// File: rtl/score_event_conditioner.sv
// Purpose: sync, debounce and re-arm-lock the raw Arduino score line; emit one score_pulse per press.
// Latency: score_pulse rises DEBOUNCE_CYCLES+3 cycles after the first edge that samples score_in stably high.
// Backpressure: none; free-running event conditioner. Optional macro: SCORE_REJECT_COUNT_EN adds rejected_count.
module score_event_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LOCKOUT_CYCLES  = 25000000,
  parameter int CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             score_in,
  input  logic             game_active,
  output logic             score_pulse,
  output logic [CNT_W-1:0] score_count,
  output logic             debounced_level,
`ifdef SCORE_REJECT_COUNT_EN
  output logic [CNT_W-1:0] rejected_count,
`endif
  output logic             busy
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LO_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LO_W-1:0] LO_LOAD = LO_W'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    HELD    = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d, deb_prev_q, rise_q;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [LO_W-1:0]  lock_q, lock_d;
  state_e           state_q, state_d;
  logic             ga_q;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept, game_start;

  // Two-flop synchroniser on the asynchronous score line
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= score_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing cycles, flip the level when the run is long enough
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d    = ~deb_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Debounced level, its previous value and the registered rising-edge event
  always_ff @(posedge clock) begin
    if (!reset) begin
      deb_q      <= 1'b0;
      db_cnt_q   <= '0;
      deb_prev_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      deb_q      <= deb_d;
      db_cnt_q   <= db_cnt_d;
      deb_prev_q <= deb_q;
      rise_q     <= deb_q & ~deb_prev_q;
    end
  end

  // FSM state register together with the lockout down-counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ARMED;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // Next state: any rise leaves ARMED; release starts lockout; expiry re-arms only if released
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    unique case (state_q)
      ARMED: begin
        if (rise_q) state_d = HELD;
      end
      HELD: begin
        if (!deb_q) begin
          state_d = LOCKOUT;
          lock_d  = LO_LOAD;
        end
      end
      LOCKOUT: begin
        if (lock_q == '0) state_d = deb_q ? HELD : ARMED;
        else              lock_d  = lock_q - LO_W'(1);
      end
      default: begin
        state_d = ARMED;
        lock_d  = '0;
      end
    endcase
  end

  // Outputs: accept only in ARMED while the game runs; a new game clears the counters first
  always_comb begin
    game_start = game_active & ~ga_q;
    accept     = (state_q == ARMED) & rise_q & game_active;
    pulse_d    = accept;
    busy_d     = (state_q != ARMED);
    count_d    = game_start ? '0 : count_q;
    if (accept && (count_d != '1)) count_d = count_d + CNT_W'(1);
  end

  // Registered outputs and game_active history
  always_ff @(posedge clock) begin
    if (!reset) begin
      ga_q    <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      ga_q    <= game_active;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

`ifdef SCORE_REJECT_COUNT_EN
  logic [CNT_W-1:0] rej_q, rej_d;
  logic             reject;

  // Discarded rises: idle-game press while ARMED, or any press landing in lockout
  always_comb begin
    reject = rise_q & (((state_q == ARMED) & ~game_active) | (state_q == LOCKOUT));
    rej_d  = game_start ? '0 : rej_q;
    if (reject && (rej_d != '1)) rej_d = rej_d + CNT_W'(1);
  end

  // Rejected-event counter register
  always_ff @(posedge clock) begin
    if (!reset) rej_q <= '0;
    else        rej_q <= rej_d;
  end

  assign rejected_count = rej_q;
`endif

  assign score_pulse     = pulse_q;
  assign score_count     = count_q;
  assign debounced_level = deb_q;
  assign busy            = busy_q;

endmodule

// File: doc/score_event_conditioner.md
Name: score_event_conditioner

Overview:
- Conditions the raw score-increment line from the Arduino before it reaches the processor's score path.
- Synchronises the line, debounces it and enforces a re-arm lockout.
- Gates events with game_active and emits exactly one single-cycle score_pulse per genuine press.
- Also keeps a per-game accepted-event count for display and debug.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to change debounced level (5 ms at 100 MHz); must be >= 2.
- LOCKOUT_CYCLES, 25000000, cycles after debounced release before a new press is accepted (250 ms); must be >= 1.
- CNT_W, 16, width of score_count.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low (0 = reset asserted), sampled on clock rising edge.
- score_in  in  1  raw asynchronous score line from Arduino; active-high.
- game_active  in  1  1 while the game timer is running.
- score_pulse  out  1  one-cycle pulse per accepted event.
- score_count  out  CNT_W  accepted events since last game start; saturating.
- debounced_level  out  1  current debounced level of score_in.
- busy  out  1  1 when state is HELD or LOCKOUT.

Behaviour:
- Reset (reset==0 at an edge): sync FFs, debounced_level, score_pulse, score_count, busy, both counters and game_active history register all go to 0; state = ARMED. Reset mid-operation aborts any debounce or lockout in progress.
- Synchroniser: 2 flops on score_in, no logic between them.
- Debouncer:
  - Counter increments while sync output != debounced_level; clears to 0 on any cycle they agree.
  - When the counter would reach DEBOUNCE_CYCLES, debounced_level toggles and the counter clears.
- Rise event: debounced_level 0->1, registered. Latency from first edge sampling score_in stably high to score_pulse high is exactly DEBOUNCE_CYCLES+3 cycles.
- FSM:
  - ARMED: on rise event, if game_active==1 then score_pulse=1 for one cycle and score_count increments; if game_active==0, no pulse and no count change. Either way go to HELD.
  - HELD: wait for debounced_level==0, then load lockout counter with LOCKOUT_CYCLES and go to LOCKOUT.
  - LOCKOUT: decrement each cycle; rise events are ignored (no pulse). At counter==0: go to ARMED if debounced_level==0, else go to HELD.
- busy = (state != ARMED), registered.
- score_count:
  - Clears to 0 on a game_active 0->1 transition (compared with a registered copy).
  - If an accepted event lands in the same cycle as the clear, the result is 1.
  - Saturates at 2^CNT_W-1; further accepted events still pulse but the count holds.
- game_active falling during HELD or LOCKOUT: no effect on the FSM; only acceptance in ARMED is gated.
- score_pulse is never high two consecutive cycles; at most one pulse per ARMED->HELD transition.

Optional Feature:
- Macro: SCORE_REJECT_COUNT_EN.
- Defined:
  - Adds output port rejected_count (out, CNT_W), reset 0, cleared on game_active 0->1 together with score_count, saturating.
  - Increments once per rise event that is discarded: either ARMED with game_active==0, or any rise event while in LOCKOUT.
- Undefined: port absent, no rejection logic; all other behaviour identical.

Test Plan (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10, CNT_W=2 unless noted):
1. Hold reset=0 for 3 cycles with score_in=1 and game_active=1 -> all outputs 0 throughout; after release, the first pulse appears only after the full debounce.
2. game_active=1, score_in 0->1 held 30 cycles -> exactly one score_pulse, 7 cycles after first high sample; score_count=1; busy=1 from the next cycle.
3. score_in toggles every 2 cycles for 12 cycles, then stays high -> no pulse during bouncing; one pulse 7 cycles after the final stable-high sample.
4. After a debounced release, re-press 3 cycles into lockout and hold 20 cycles -> no pulse; at lockout expiry state=HELD, busy stays 1. Release, wait 10+ cycles, press -> one pulse; score_count=2. With SCORE_REJECT_COUNT_EN: rejected_count=1.
5. game_active=0 with a clean press -> no pulse, score_count unchanged, busy=1 until release+lockout. With SCORE_REJECT_COUNT_EN: rejected_count increments by 1.
6. Five accepted presses -> score_count sticks at 3, and all five score_pulses occur. Then toggle game_active 1->0->1 -> score_count=0. Assert reset=0 in LOCKOUT -> busy=0, state ARMED next cycle.
